// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK latch bank sequencer: opcodes, FSM states
// and a constant clog2 helper.
package jk_seq_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/jk_bank_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int GIDW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GIDW-1:0] ptr,
  output logic [GIDW-1:0] grant,
  output logic            valid
);

  logic [GIDW-1:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = GIDW'((int'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Shares a bank of JK latches between NREQ requesters: round-robin grant,
// then a setup / pulse / hold sequence on one latch with readback check.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int  NREQ  = 4,
  parameter int  WIDTH = 8,
  parameter int  IDXW  = 3,
  localparam int GIDW  = clog2(NREQ)
) (
  input  logic                 Clk,
  input  logic                 Clear,
  input  logic [NREQ-1:0]      Req,
  input  logic [2*NREQ-1:0]    Op,
  input  logic [IDXW*NREQ-1:0] Idx,
  input  logic [WIDTH-1:0]     Q_bank,
  output logic [WIDTH-1:0]     J_bank,
  output logic [WIDTH-1:0]     K_bank,
  output logic [WIDTH-1:0]     En_bank,
  output logic [NREQ-1:0]      Ack,
  output logic                 Err,
  output logic                 Busy,
  output logic [GIDW-1:0]      Grant_id,
  output logic [2:0]           state_dbg
);

  // Handshake: a requester raises Req with Op/Idx stable and holds all three
  // until it sees its one-cycle Ack; the op is captured at grant time.

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t          state, state_nx;
  logic [GIDW-1:0] ptr;
  logic [GIDW-1:0] arb_grant;
  logic            arb_valid;
  logic [1:0]      op_r;
  logic [IDXW-1:0] idx_r;
  logic            q0_r;
  logic            exp_r;
  logic            q_tgt;
  logic            q_src;
  logic            j_bit;
  logic            k_bit;
  logic            exp_nx;
  logic [WIDTH-1:0] onehot;

  rr_arbiter #(.NREQ(NREQ), .GIDW(GIDW)) u_arb (
    .req   (Req),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign q_tgt     = Q_bank[idx_r];
  assign onehot    = ONE << idx_r;
  assign state_dbg = state;

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      Grant_id <= '0;
      op_r     <= OP_HOLD;
      idx_r    <= '0;
      q0_r     <= 1'b0;
      exp_r    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && arb_valid) begin
        op_r     <= Op[2*int'(arb_grant) +: 2];
        idx_r    <= Idx[IDXW*int'(arb_grant) +: IDXW];
        Grant_id <= arb_grant;
        ptr      <= GIDW'((int'(arb_grant) + 1) % NREQ);
      end
      if (state == ST_SETUP) begin
        q0_r  <= q_tgt;
        exp_r <= exp_nx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (arb_valid) state_nx = ST_SETUP;
      ST_SETUP: state_nx = ST_PULSE;
      ST_PULSE: state_nx = ST_HOLD;
      ST_HOLD:  state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // TOGGLE reads Q live in SETUP, then uses the sampled copy so the pulse
  // cannot feed its own result back into J/K.
  always_comb begin
    q_src  = (state == ST_SETUP) ? q_tgt : q0_r;
    j_bit  = 1'b0;
    k_bit  = 1'b0;
    exp_nx = q_tgt;
    case (op_r)
      OP_SET:    begin j_bit = 1'b1;   k_bit = 1'b0;  exp_nx = 1'b1;   end
      OP_RESET:  begin j_bit = 1'b0;   k_bit = 1'b1;  exp_nx = 1'b0;   end
      OP_TOGGLE: begin j_bit = ~q_src; k_bit = q_src; exp_nx = ~q_tgt; end
      default:   begin j_bit = 1'b0;   k_bit = 1'b0;  exp_nx = q_tgt;  end
    endcase
  end

  always_comb begin
    J_bank  = '0;
    K_bank  = '0;
    En_bank = '0;
    Ack     = '0;
    Err     = 1'b0;
    Busy    = (state != ST_IDLE);
    case (state)
      ST_SETUP, ST_HOLD: begin
        J_bank = j_bit ? onehot : '0;
        K_bank = k_bit ? onehot : '0;
      end
      ST_PULSE: begin
        J_bank  = j_bit ? onehot : '0;
        K_bank  = k_bit ? onehot : '0;
        En_bank = (op_r != OP_HOLD) ? onehot : '0;
      end
      ST_DONE: begin
        Ack[Grant_id] = 1'b1;
        Err           = (q_tgt != exp_r);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: behavioural latch bank, directed scenarios and
// randomized ops checked against a bench-side model of the latch contents.
module tb_jk_bank_sequencer;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic        Clk, Clear;
  logic [3:0]  Req;
  logic [7:0]  Op;
  logic [11:0] Idx;
  logic [7:0]  Q_bank, J_bank, K_bank, En_bank;
  logic [3:0]  Ack;
  logic        Err, Busy;
  logic [1:0]  Grant_id;
  logic [2:0]  state_dbg;

  jk_bank_sequencer dut (
    .Clk(Clk), .Clear(Clear), .Req(Req), .Op(Op), .Idx(Idx), .Q_bank(Q_bank),
    .J_bank(J_bank), .K_bank(K_bank), .En_bank(En_bank), .Ack(Ack), .Err(Err),
    .Busy(Busy), .Grant_id(Grant_id), .state_dbg(state_dbg)
  );

  // clock / latch bank model
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] lat, load_val, stuck0, model_bank;
  logic       load_en;
  assign Q_bank = lat & ~stuck0;

  always @(posedge Clk) begin
    if (load_en) lat <= load_val;
    else
      for (int i = 0; i < 8; i++)
        if (En_bank[i])
          case ({J_bank[i], K_bank[i]})
            2'b10: lat[i] <= 1'b1;
            2'b01: lat[i] <= 1'b0;
            2'b11: lat[i] <= ~lat[i];
            default: ;
          endcase
  end

  int inv_viol = 0;
  always @(negedge Clk)
    if (Clear === 1'b1 && (((J_bank & K_bank) != 8'h00) || $countones(En_bank) > 1))
      inv_viol++;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] obs_j[0:15], obs_k[0:15], obs_en[0:15];
  logic [3:0] obs_ack[0:15];
  logic       obs_err[0:15];
  logic [1:0] obs_gid[0:15];
  int         ack_at;

  // driver tasks
  task automatic load_bank(input logic [7:0] v);
    load_val = v;
    load_en = 1'b1;
    @(negedge Clk);
    load_en = 1'b0;
    model_bank = v;
  endtask

  task automatic run_op(input int r, input logic [1:0] op, input logic [2:0] idx, input bit scramble);
    @(negedge Clk);
    Req = 4'b0001 << r;
    Op[2*r +: 2] = op;
    Idx[3*r +: 3] = idx;
    ack_at = -1;
    for (int k = 0; k < 16; k++) begin
      obs_j[k] = '0; obs_k[k] = '0; obs_en[k] = '0; obs_ack[k] = '0; obs_err[k] = 1'b0; obs_gid[k] = '0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      obs_j[k] = J_bank; obs_k[k] = K_bank; obs_en[k] = En_bank;
      obs_ack[k] = Ack; obs_err[k] = Err; obs_gid[k] = Grant_id;
      if (scramble && k == 1) begin
        Op[2*r +: 2] = 2'($urandom_range(0, 3));
        Idx[3*r +: 3] = 3'($urandom_range(0, 7));
      end
      if (Ack != 4'b0000) begin
        ack_at = k;
        Req = 4'b0000;
        break;
      end
    end
  endtask

  function automatic logic target_value(input logic [1:0] op, input logic q);
    case (op)
      OP_SET:    return 1'b1;
      OP_RESET:  return 1'b0;
      OP_TOGGLE: return ~q;
      default:   return q;
    endcase
  endfunction

  function automatic int next_grant(input logic [3:0] req, input int ptr);
    for (int i = 0; i < 4; i++)
      if (req[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  // scenarios
  task automatic test_reset();
    Clear = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({J_bank, K_bank, En_bank, Ack, Err, Busy, Grant_id} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {J_bank, K_bank, En_bank, Ack, Err, Busy, Grant_id});
    end
    Clear = 1'b1;
    load_bank(8'h00);
    Req = 4'b0001; Op[1:0] = OP_SET; Idx[2:0] = 3'd5;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if (En_bank !== 8'h20) begin n_fail++; $display("FAIL reset_pre_pulse_en: got %h expected 20", En_bank); end
    Clear = 1'b0;
    #1;
    n_cmp++;
    if ({En_bank, J_bank, K_bank, Ack, Busy, Grant_id} !== 31'h0) begin
      n_fail++; $display("FAIL reset_mid_pulse: got %h expected 0", {En_bank, J_bank, K_bank, Ack, Busy, Grant_id});
    end
    @(negedge Clk);
    Clear = 1'b1;
    ack_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (Ack != 4'b0000) begin
        ack_at = k;
        n_cmp++;
        if (Ack !== 4'b0001) begin n_fail++; $display("FAIL reset_rerun_ack: got %b expected 0001", Ack); end
        Req = 4'b0000;
        break;
      end
    end
    n_cmp++;
    if (ack_at !== 4) begin n_fail++; $display("FAIL reset_rerun_latency: got %0d expected 4", ack_at); end
    model_bank[5] = 1'b1;
    n_cmp++;
    if (Q_bank !== model_bank) begin n_fail++; $display("FAIL reset_rerun_q: got %h expected %h", Q_bank, model_bank); end
  endtask

  task automatic test_set();
    load_bank(8'h00);
    run_op(1, OP_SET, 3'd2, 1'b0);
    n_cmp++;
    if (ack_at !== 4) begin n_fail++; $display("FAIL set_latency: got %0d expected 4", ack_at); end
    n_cmp++;
    if ({obs_j[1], obs_j[2], obs_j[3], obs_j[4]} !== 32'h04040400) begin
      n_fail++; $display("FAIL set_j: got %h expected 04040400", {obs_j[1], obs_j[2], obs_j[3], obs_j[4]});
    end
    n_cmp++;
    if ({obs_k[1], obs_k[2], obs_k[3], obs_k[4], obs_en[1], obs_en[2], obs_en[3], obs_en[4]} !== 64'h0000000000040000) begin
      n_fail++; $display("FAIL set_k_en: got %h expected 0000000000040000",
                         {obs_k[1], obs_k[2], obs_k[3], obs_k[4], obs_en[1], obs_en[2], obs_en[3], obs_en[4]});
    end
    n_cmp++;
    if ({obs_ack[4], obs_err[4], obs_gid[1]} !== 7'b0010_0_01) begin
      n_fail++; $display("FAIL set_ack_err_gid: got %b expected 0010001", {obs_ack[4], obs_err[4], obs_gid[1]});
    end
    n_cmp++;
    if (Q_bank !== 8'h04) begin n_fail++; $display("FAIL set_q: got %h expected 04", Q_bank); end
  endtask

  task automatic test_toggle();
    load_bank(8'h80);
    run_op(0, OP_TOGGLE, 3'd7, 1'b0);
    n_cmp++;
    if ({obs_j[1], obs_j[2], obs_j[3], obs_k[1], obs_k[2], obs_k[3], obs_en[2]} !== 56'h000000_808080_80) begin
      n_fail++; $display("FAIL toggle1_jk: got %h expected 00000080808080",
                         {obs_j[1], obs_j[2], obs_j[3], obs_k[1], obs_k[2], obs_k[3], obs_en[2]});
    end
    n_cmp++;
    if ({Q_bank, obs_err[4], 4'(ack_at)} !== {8'h00, 1'b0, 4'd4}) begin
      n_fail++; $display("FAIL toggle1_q: got %h expected 004", {Q_bank, obs_err[4], 4'(ack_at)});
    end
    run_op(0, OP_TOGGLE, 3'd7, 1'b0);
    n_cmp++;
    if ({obs_j[1], obs_j[2], obs_j[3], obs_k[1], obs_k[2], obs_k[3], obs_en[2]} !== 56'h808080_000000_80) begin
      n_fail++; $display("FAIL toggle2_jk: got %h expected 80808000000080",
                         {obs_j[1], obs_j[2], obs_j[3], obs_k[1], obs_k[2], obs_k[3], obs_en[2]});
    end
    n_cmp++;
    if ({Q_bank, obs_err[4], 4'(ack_at)} !== {8'h80, 1'b0, 4'd4}) begin
      n_fail++; $display("FAIL toggle2_q: got %h expected 1004", {Q_bank, obs_err[4], 4'(ack_at)});
    end
  endtask

  task automatic test_fairness();
    int cnt, last, exp_id, exp_ptr;
    Clear = 1'b0;
    @(negedge Clk);
    Clear = 1'b1;
    load_bank(8'h00);
    Op = {OP_SET, OP_SET, OP_SET, OP_SET};
    Idx = {3'd3, 3'd2, 3'd1, 3'd0};
    exp_ptr = 0;
    for (int phase = 0; phase < 2; phase++) begin
      Req = (phase == 0) ? 4'b1111 : 4'b1010;
      cnt = 0;
      last = 0;
      for (int c = 0; c < 60 && cnt < ((phase == 0) ? 8 : 3); c++) begin
        @(negedge Clk);
        if (Ack != 4'b0000) begin
          exp_id = next_grant(Req, exp_ptr);
          n_cmp++;
          if (Ack !== (4'b0001 << exp_id)) begin
            n_fail++; $display("FAIL fair_order: got %b expected %b", Ack, 4'b0001 << exp_id);
          end
          if (cnt > 0) begin
            n_cmp++;
            if (c - last !== 5) begin n_fail++; $display("FAIL fair_spacing: got %0d expected 5", c - last); end
          end
          last = c;
          exp_ptr = (exp_id + 1) % 4;
          cnt++;
        end
      end
      Req = 4'b0000;
      n_cmp++;
      if (cnt !== ((phase == 0) ? 8 : 3)) begin
        n_fail++; $display("FAIL fair_count: got %0d expected %0d", cnt, (phase == 0) ? 8 : 3);
      end
      repeat (2) @(negedge Clk);
    end
    load_bank(8'h00);
  endtask

  task automatic test_readback_err();
    load_bank(8'h00);
    stuck0 = 8'h10;
    run_op(2, OP_SET, 3'd4, 1'b0);
    n_cmp++;
    if ({obs_err[1], obs_err[2], obs_err[3], obs_err[4], obs_ack[4], 4'(ack_at)} !== 12'b0001_0100_0100) begin
      n_fail++; $display("FAIL readback_err: got %b expected 000101000100",
                         {obs_err[1], obs_err[2], obs_err[3], obs_err[4], obs_ack[4], 4'(ack_at)});
    end
    stuck0 = 8'h00;
    load_bank(8'h00);
  endtask

  task automatic test_hold();
    load_bank(8'h01);
    run_op(3, OP_HOLD, 3'd0, 1'b0);
    n_cmp++;
    if ({obs_en[1], obs_en[2], obs_en[3], obs_en[4], obs_j[2], obs_k[2]} !== 48'h0) begin
      n_fail++; $display("FAIL hold_quiet: got %h expected 0",
                         {obs_en[1], obs_en[2], obs_en[3], obs_en[4], obs_j[2], obs_k[2]});
    end
    n_cmp++;
    if ({obs_ack[4], obs_err[4], 4'(ack_at), Q_bank} !== {4'b1000, 1'b0, 4'd4, 8'h01}) begin
      n_fail++; $display("FAIL hold_ack: got %h expected 10401", {obs_ack[4], obs_err[4], 4'(ack_at), Q_bank});
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] op;
    logic [2:0] idx;
    logic d;
    logic [7:0] oh, ej, ek, een;
    load_bank(8'($urandom_range(0, 255)));
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 3);
      op = 2'($urandom_range(0, 3));
      idx = 3'($urandom_range(0, 7));
      d = target_value(op, model_bank[idx]);
      oh = 8'h01 << idx;
      ej = (op != OP_HOLD && d) ? oh : 8'h00;
      ek = (op != OP_HOLD && !d) ? oh : 8'h00;
      een = (op != OP_HOLD) ? oh : 8'h00;
      run_op(r, op, idx, t[0]);
      model_bank[idx] = d;
      n_cmp++;
      if ({obs_j[1], obs_j[2], obs_j[3], obs_j[4]} !== {ej, ej, ej, 8'h00}) begin
        n_fail++; $display("FAIL rand_j op%0d: got %h expected %h", t, {obs_j[1], obs_j[2], obs_j[3], obs_j[4]}, {ej, ej, ej, 8'h00});
      end
      n_cmp++;
      if ({obs_k[1], obs_k[2], obs_k[3], obs_k[4]} !== {ek, ek, ek, 8'h00}) begin
        n_fail++; $display("FAIL rand_k op%0d: got %h expected %h", t, {obs_k[1], obs_k[2], obs_k[3], obs_k[4]}, {ek, ek, ek, 8'h00});
      end
      n_cmp++;
      if ({obs_en[1], obs_en[2], obs_en[3], obs_en[4]} !== {8'h00, een, 8'h00, 8'h00}) begin
        n_fail++; $display("FAIL rand_en op%0d: got %h expected %h", t, {obs_en[1], obs_en[2], obs_en[3], obs_en[4]}, {8'h00, een, 8'h00, 8'h00});
      end
      n_cmp++;
      if ({obs_ack[4], obs_err[4], obs_gid[1], 4'(ack_at)} !== {4'b0001 << r, 1'b0, 2'(r), 4'd4}) begin
        n_fail++; $display("FAIL rand_ack op%0d: got %h expected %h", t, {obs_ack[4], obs_err[4], obs_gid[1], 4'(ack_at)}, {4'b0001 << r, 1'b0, 2'(r), 4'd4});
      end
      n_cmp++;
      if (Q_bank !== model_bank) begin
        n_fail++; $display("FAIL rand_q op%0d: got %h expected %h", t, Q_bank, model_bank);
      end
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (inv_viol !== 0) begin n_fail++; $display("FAIL invariants: got %0d violations expected 0", inv_viol); end
  endtask

  initial begin
    Clear = 1'b0; Req = '0; Op = '0; Idx = '0;
    load_en = 1'b0; load_val = '0; stuck0 = '0; lat = '0; model_bank = '0;
    test_reset();
    test_set();
    test_toggle();
    test_fairness();
    test_readback_err();
    test_hold();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
